// File: rtl/regfile_write_arbiter_if.sv
// Write-request bus between the two register-file writers and the arbiter.
// REGARB_STATS_EN adds the conflict_cnt statistics signal.
interface regfile_write_arbiter_if #(
  parameter int WordLen = 32,
  parameter int AddrLen = 4
);
  logic               req0_valid;
  logic [AddrLen-1:0] req0_addr;
  logic [WordLen-1:0] req0_data;
  logic               req0_ready;
  logic               req1_valid;
  logic [AddrLen-1:0] req1_addr;
  logic [WordLen-1:0] req1_data;
  logic               req1_ready;
  logic               rf_write;
  logic [AddrLen-1:0] rf_addr;
  logic [WordLen-1:0] rf_data;
  logic [3:0]         stall_cnt;
`ifdef REGARB_STATS_EN
  logic [15:0]        conflict_cnt;
`endif

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  rf_write, rf_addr, rf_data,
    input  stall_cnt
`ifdef REGARB_STATS_EN
    , input conflict_cnt
`endif
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output rf_write, rf_addr, rf_data,
    output stall_cnt
`ifdef REGARB_STATS_EN
    , output conflict_cnt
`endif
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-writer arbiter for the register-file write port, port 0 priority.
// Define REGARB_STATS_EN to add the conflict_cnt statistics counter.
module regfile_write_arbiter #(
  parameter int WordLen = 32,
  parameter int AddrLen = 4,
  parameter int MaxWait = 4
) (
  input logic clk,
  input logic rst,
  regfile_write_arbiter_if.slave bus
);
  localparam logic [3:0] MaxCnt = 4'(MaxWait);

  logic               wr_q, wr_d;
  logic [AddrLen-1:0] addr_q, addr_d;
  logic [WordLen-1:0] data_q, data_d;
  logic [3:0]         stall_q, stall_d;
  logic               starve;
  logic               gnt0, gnt1;

  always_comb begin
    starve = (stall_q == MaxCnt);
    gnt1 = ~rst & bus.req1_valid
         & (~bus.req0_valid | starve);
    gnt0 = ~rst & bus.req0_valid
         & ~(bus.req1_valid & starve);
  end

  always_comb begin
    wr_d   = gnt0 | gnt1;
    addr_d = addr_q;
    data_d = data_q;
    unique case (1'b1)
      gnt1: begin
        addr_d = bus.req1_addr;
        data_d = bus.req1_data;
      end
      gnt0: begin
        addr_d = bus.req0_addr;
        data_d = bus.req0_data;
      end
      default: ;
    endcase
    // wait count only grows while port 1 is actively being refused
    stall_d = stall_q;
    if (!bus.req1_valid || gnt1) begin
      stall_d = '0;
    end else if (stall_q != MaxCnt) begin
      stall_d = stall_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      stall_q <= '0;
    end else begin
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      stall_q <= stall_d;
    end
  end

`ifdef REGARB_STATS_EN
  logic [15:0] conf_q, conf_d;

  always_comb begin
    conf_d = conf_q;
    if (bus.req0_valid && bus.req1_valid
        && conf_q != 16'hFFFF) begin
      conf_d = conf_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conf_q <= '0;
    end else begin
      conf_q <= conf_d;
    end
  end

  assign bus.conflict_cnt = conf_q;
`endif

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.rf_write   = wr_q;
  assign bus.rf_addr    = addr_q;
  assign bus.rf_data    = data_q;
  assign bus.stall_cnt  = stall_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter (MaxWait=4).
// Expected writes are queued at acceptance and popped on rf_write.
module tb_regfile_write_arbiter;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.WordLen(32), .AddrLen(4)) bus ();

  regfile_write_arbiter #(
    .WordLen(32),
    .AddrLen(4),
    .MaxWait(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [3:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t sb[$];
  int total = 0;
  int bad   = 0;

  always @(negedge clk) begin : monitor
    wr_t e;
    if (bus.rf_write === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL rf_unexpected got=%0h/%0h want=none",
                 bus.rf_addr, bus.rf_data);
      end else begin
        e = sb.pop_front();
        if ({bus.rf_addr, bus.rf_data} !== e) begin
          bad++;
          $display("FAIL rf_write got=%0h/%0h want=%0h/%0h",
                   bus.rf_addr, bus.rf_data, e.a, e.d);
        end
      end
    end
  end

  task automatic drive(input logic r,
                       input logic v0, input logic [3:0] a0,
                       input logic [31:0] d0,
                       input logic v1, input logic [3:0] a1,
                       input logic [31:0] d1);
    @(posedge clk);
    #1;
    rst = r;
    bus.req0_valid = v0;
    bus.req0_addr  = a0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_addr  = a1;
    bus.req1_data  = d1;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 4'd9;
    bus.req0_data  = 32'h99;
    bus.req1_valid = 1'b0;
    bus.req1_addr  = 4'd0;
    bus.req1_data  = 32'd0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (bus.req0_ready !== 1'b0) begin
        bad++;
        $display("FAIL rst_ready0 got=%b want=0", bus.req0_ready);
      end
      total++;
      if (bus.rf_write !== 1'b0) begin
        bad++;
        $display("FAIL rst_rf_write got=%b want=0", bus.rf_write);
      end
      total++;
      if (bus.stall_cnt !== 4'd0) begin
        bad++;
        $display("FAIL rst_stall got=%0d want=0", bus.stall_cnt);
      end
    end
    drive(1'b0, 1'b1, 4'd9, 32'h99, 1'b0, 4'd0, 32'd0);
    total++;
    if (bus.req0_ready !== 1'b1) begin
      bad++;
      $display("FAIL first_accept got=%b want=1", bus.req0_ready);
    end
    sb.push_back('{a: 4'd9, d: 32'h99});
    idle();
  endtask

  task automatic test_port0();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 4'(i + 1), 32'hA + 32'(i),
            1'b0, 4'd0, 32'd0);
      total++;
      if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
        bad++;
        $display("FAIL p0_ready got=%b%b want=10",
                 bus.req0_ready, bus.req1_ready);
      end
      sb.push_back('{a: 4'(i + 1), d: 32'hA + 32'(i)});
      if (i > 0) begin
        total++;
        if (bus.rf_write !== 1'b1) begin
          bad++;
          $display("FAIL p0_b2b got=%b want=1", bus.rf_write);
        end
      end
    end
    idle();
    total++;
    if (bus.rf_write !== 1'b1) begin
      bad++;
      $display("FAIL p0_last got=%b want=1", bus.rf_write);
    end
  endtask

  task automatic test_port1();
    drive(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 32'h1234);
    total++;
    if (bus.req1_ready !== 1'b1 || bus.stall_cnt !== 4'd0) begin
      bad++;
      $display("FAIL p1_accept got=%b/%0d want=1/0",
               bus.req1_ready, bus.stall_cnt);
    end
    sb.push_back('{a: 4'd5, d: 32'h1234});
    idle();
    total++;
    if (bus.stall_cnt !== 4'd0 || bus.rf_write !== 1'b1) begin
      bad++;
      $display("FAIL p1_after got=%0d/%b want=0/1",
               bus.stall_cnt, bus.rf_write);
    end
  endtask

  task automatic test_starvation();
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1, 4'(8 + k), 32'h100 + 32'(k),
            1'b1, 4'd7, 32'hDEAD);
      total++;
      if (bus.stall_cnt !== 4'(k)) begin
        bad++;
        $display("FAIL starve_cnt got=%0d want=%0d", bus.stall_cnt, k);
      end
      total++;
      if (k < 4) begin
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
          bad++;
          $display("FAIL starve_wait got=%b%b want=10",
                   bus.req0_ready, bus.req1_ready);
        end
        sb.push_back('{a: 4'(8 + k), d: 32'h100 + 32'(k)});
      end else begin
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b1) begin
          bad++;
          $display("FAIL starve_grant got=%b%b want=01",
                   bus.req0_ready, bus.req1_ready);
        end
        sb.push_back('{a: 4'd7, d: 32'hDEAD});
      end
    end
    drive(1'b0, 1'b1, 4'd12, 32'h104, 1'b0, 4'd0, 32'd0);
    total++;
    if (bus.stall_cnt !== 4'd0 || bus.req0_ready !== 1'b1) begin
      bad++;
      $display("FAIL starve_resume got=%0d/%b want=0/1",
               bus.stall_cnt, bus.req0_ready);
    end
    sb.push_back('{a: 4'd12, d: 32'h104});
    idle();
  endtask

  task automatic test_collision();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 4'(10 + k), 32'(k), 1'b1, 4'd3, 32'h22);
      total++;
      if (bus.req0_ready !== 1'b1) begin
        bad++;
        $display("FAIL coll_pre got=%b want=1", bus.req0_ready);
      end
      sb.push_back('{a: 4'(10 + k), d: 32'(k)});
    end
    drive(1'b0, 1'b1, 4'd3, 32'h11, 1'b1, 4'd3, 32'h22);
    total++;
    if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin
      bad++;
      $display("FAIL coll_grant got=%b%b want=01",
               bus.req0_ready, bus.req1_ready);
    end
    sb.push_back('{a: 4'd3, d: 32'h22});
    drive(1'b0, 1'b1, 4'd3, 32'h11, 1'b0, 4'd0, 32'd0);
    total++;
    if (bus.req0_ready !== 1'b1) begin
      bad++;
      $display("FAIL coll_second got=%b want=1", bus.req0_ready);
    end
    sb.push_back('{a: 4'd3, d: 32'h11});
    idle();
  endtask

  task automatic test_addr0();
    drive(1'b0, 1'b1, 4'd0, 32'h55, 1'b0, 4'd0, 32'd0);
    total++;
    if (bus.req0_ready !== 1'b1) begin
      bad++;
      $display("FAIL addr0_ready got=%b want=1", bus.req0_ready);
    end
    sb.push_back('{a: 4'd0, d: 32'h55});
    idle();
  endtask

  task automatic test_midreset();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b1, 4'd1, 32'h1, 1'b1, 4'd6, 32'h66);
      sb.push_back('{a: 4'd1, d: 32'h1});
    end
    drive(1'b0, 1'b1, 4'd4, 32'h44, 1'b1, 4'd6, 32'h66);
    total++;
    if (bus.req0_ready !== 1'b1 || bus.stall_cnt !== 4'd2) begin
      bad++;
      $display("FAIL mid_pre got=%b/%0d want=1/2",
               bus.req0_ready, bus.stall_cnt);
    end
    sb.push_back('{a: 4'd4, d: 32'h44});
    drive(1'b1, 1'b1, 4'd5, 32'h5, 1'b1, 4'd6, 32'h66);
    total++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_rst_ready got=%b%b want=00",
               bus.req0_ready, bus.req1_ready);
    end
    drive(1'b1, 1'b1, 4'd5, 32'h5, 1'b1, 4'd6, 32'h66);
    total++;
    if (bus.rf_write !== 1'b0 || bus.stall_cnt !== 4'd0) begin
      bad++;
      $display("FAIL mid_rst got=%b/%0d want=0/0",
               bus.rf_write, bus.stall_cnt);
    end
`ifdef REGARB_STATS_EN
    total++;
    if (bus.conflict_cnt !== 16'd0) begin
      bad++;
      $display("FAIL mid_conflict got=%0d want=0", bus.conflict_cnt);
    end
`endif
    idle();
    total++;
    if (bus.rf_write !== 1'b0) begin
      bad++;
      $display("FAIL mid_release got=%b want=0", bus.rf_write);
    end
  endtask

  initial begin
    test_reset();
    test_port0();
    test_port1();
    test_starvation();
    test_collision();
    test_addr0();
    test_midreset();
    idle();
    idle();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single write port of the 16x32 register file between two writers.
- Port 0 is the pipeline write-back stage.
- Port 1 is a multi-cycle unit (multiplier / load-multiple sequencer).
Port 0 has priority. A starvation counter forces a port-1 grant after a bounded wait. The selected write is registered and driven onto the register file's regWrite / writeRegister / writeData inputs.

Parameters:
WordLen, 32, data width of each write request and of the write port.
AddrLen, 4, register index width (16 registers).
MaxWait, 4, consecutive port-1 stall cycles after which port 1 is granted over port 0 (legal range 1..15).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
req0_valid  input  1  port 0 (write-back) has a write.
req0_addr  input  AddrLen  port 0 destination register.
req0_data  input  WordLen  port 0 write data.
req0_ready  output  1  port 0 write accepted this cycle.
req1_valid  input  1  port 1 (multi-cycle unit) has a write.
req1_addr  input  AddrLen  port 1 destination register.
req1_data  input  WordLen  port 1 write data.
req1_ready  output  1  port 1 write accepted this cycle.
rf_write  output  1  to register file regWrite.
rf_addr  output  AddrLen  to register file writeRegister.
rf_data  output  WordLen  to register file writeData.
stall_cnt  output  4  current port-1 wait count (debug/hazard use).

Behaviour:
- Reset: already decided — one clock; reset is synchronous and active-high (clk, rst).
- While rst=1: req0_ready=0, req1_ready=0, rf_write=0, rf_addr=0, rf_data=0, stall_cnt=0. Requests presented during reset are not accepted; requesters hold them.
- Handshake: a transfer occurs on a rising edge where valid=1 and ready=1. A requester holds valid, addr and data stable until accepted.
- ready is combinational from valids and stall_cnt. At most one of req0_ready / req1_ready is 1 per cycle.
- Grant rules:
  - starve = (stall_cnt == MaxWait).
  - req1_ready = req1_valid & (~req0_valid | starve).
  - req0_ready = req0_valid & ~(req1_valid & starve).
- Output register, updated each edge:
  - rf_write <= (transfer on either port).
  - rf_addr / rf_data <= the granted port's addr/data. They hold their previous value when no transfer occurs.
- Latency: exactly 1 cycle from acceptance edge to rf_write=1. The register file commits on the following falling edge.
- stall_cnt:
  - Increments when req1_valid=1 and req1_ready=0, saturating at MaxWait.
  - Clears to 0 on a port-1 transfer or when req1_valid=0.
- Address 0 is forwarded unchanged; suppression of register-0 writes is the register file's responsibility.
- Same destination on both ports in one cycle: only the granted port writes that cycle. The other writes on a later cycle, so the later-accepted value is final.
- Back-to-back port-0 writes with no port-1 request: one write per cycle, no bubbles.
- After a starve grant, stall_cnt=0. Port 0 regains priority the next cycle.
- Reset mid-operation, with rf_write pending: rf_write drops to 0 at the reset edge and the in-flight write is discarded.

Optional Feature:
REGARB_STATS_EN: adds output conflict_cnt [15:0].
- conflict_cnt increments, saturating at 16'hFFFF, on every cycle where req0_valid=1 and req1_valid=1.
- It clears on rst.
- Without the macro the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with req0_valid=1 -> req0_ready=0, rf_write=0, stall_cnt=0 throughout. First acceptance occurs on the first edge after rst falls.
- Port 0 only, addrs 1,2,3 with data 0xA,0xB,0xC on consecutive cycles -> rf_write=1 for 3 consecutive cycles, each 1 cycle after its transfer; rf_addr/rf_data = 1/0xA, 2/0xB, 3/0xC.
- Port 1 only, addr 5, data 0x1234 -> req1_ready=1 the same cycle; rf_write=1, rf_addr=5, rf_data=0x1234 next cycle; stall_cnt stays 0.
- Starvation, MaxWait=4: req0_valid held 1 (new addr each cycle), req1_valid=1 addr 7 data 0xDEAD -> stall_cnt reads 0,1,2,3,4. On the 5th cycle req1_ready=1 and req0_ready=0. Next cycle rf_addr=7, rf_data=0xDEAD, stall_cnt=0, and port 0 resumes.
- Same destination collision at starve: both ports addr 3, port 0 data 0x11, port 1 data 0x22 -> rf writes 3/0x22 then 3/0x11 on consecutive cycles.
- Mid-operation reset: port-0 transfer on cycle N, rst=1 on cycle N+1 -> rf_write=0 after the N+1 edge and stall_cnt=0; with REGARB_STATS_EN, conflict_cnt=0.
